// File: rtl/mem_arbiter_pkg.sv
// Shared widths and arbiter FSM encoding for the unified-memory arbiter.
package mem_arbiter_pkg;

    localparam int XLEN      = 32;
    localparam int ADDR_SIZE = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_WAIT = 2'd1,
        D_WAIT  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_starve_ctr.sv
// Saturating count of data grants taken while fetch was waiting.
module arb_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic if_req,
    input  logic if_abort,
    input  logic grant_if,
    input  logic grant_d,
    output logic at_max
);

    localparam logic [3:0] MAX = 4'(STARVE_MAX);

    logic [3:0] cnt_d;
    logic [3:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (!if_req || grant_if) begin
            cnt_d = 4'd0;
        end else if (grant_d && !if_abort && cnt_q != MAX) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max = (cnt_q == MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data ports onto one single-port memory,
// with registered memory handshake, ready pulses and fetch anti-starvation.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_SIZE,
    parameter int DATA_W     = XLEN,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_abort,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ready,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic                stall_if,
    output logic                stall_mem,
    output logic                busy
);

    arb_state_e          state_d, state_q;
    logic                mem_req_d, mem_req_q;
    logic                mem_we_d, mem_we_q;
    logic [DATA_W/8-1:0] mem_be_d, mem_be_q;
    logic [ADDR_W-1:0]   mem_addr_d, mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_d, mem_wdata_q;
    logic [DATA_W-1:0]   if_rdata_d, if_rdata_q;
    logic [DATA_W-1:0]   d_rdata_d, d_rdata_q;
    logic                if_ready_d, if_ready_q;
    logic                d_ready_d, d_ready_q;
    logic                disc_d, disc_q;
    logic                grant_if, grant_d;
    logic                at_max;
    logic                f_elig, d_elig;

    // A port whose ready pulse is high is finishing, not asking again.
    assign f_elig = if_req & ~if_abort & ~if_ready_q;
    assign d_elig = d_req & ~d_ready_q;

    arb_starve_ctr #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .clk     (clk),
        .reset_n (reset_n),
        .if_req  (if_req),
        .if_abort(if_abort),
        .grant_if(grant_if),
        .grant_d (grant_d),
        .at_max  (at_max)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        disc_d      = disc_q;
        grant_if    = 1'b0;
        grant_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (f_elig && (!d_elig || at_max)) begin
                    grant_if    = 1'b1;
                    state_d     = IF_WAIT;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_be_d    = '1;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    disc_d      = 1'b0;
                end else if (d_elig) begin
                    grant_d     = 1'b1;
                    state_d     = D_WAIT;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_be_d    = d_be;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                end
            end
            IF_WAIT: begin
                if (if_abort) begin
                    disc_d = 1'b1;
                end
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    disc_d    = 1'b0;
                    if (!disc_q && !if_abort) begin
                        if_ready_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end
            end
            D_WAIT: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    d_ready_d = 1'b1;
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            disc_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
            disc_q      <= disc_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_ready  = if_ready_q;
    assign d_ready   = d_ready_q;
    assign busy      = (state_q != IDLE);
    assign stall_if  = if_req & ~if_ready_q & ~if_abort;
    assign stall_mem = d_req & ~d_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Random-traffic scoreboard bench for mem_arbiter against a transaction model.
module tb_mem_arbiter;

    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        if_req = 1'b0, if_abort = 1'b0, if_ready;
    logic [31:0] if_addr = '0, if_rdata;
    logic        d_req = 1'b0, d_we = 1'b0, d_ready;
    logic [3:0]  d_be = '0;
    logic [31:0] d_addr = '0, d_wdata = '0, d_rdata;
    logic        mem_req, mem_we, mem_ack = 1'b0;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic        stall_if, stall_mem, busy;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_MAX(MAXS)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_abort(if_abort),
        .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
    );

    typedef struct packed {
        logic        fetch;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mtx_t;

    mtx_t        mq[$];
    logic [31:0] ifq[$];
    logic [31:0] dq[$];
    mtx_t        cur;

    int errs = 0;
    int checks = 0;

    // Transaction-level model: owner 0 = none, 1 = fetch, 2 = data.
    int          m_owner = 0;
    int          m_cnt = 0;
    bit          m_disc = 0, m_ifr = 0, m_dr = 0, m_dwe = 0;
    logic [31:0] m_ifrd = '0, m_drd = '0;
    int          wait_cnt = 0;
    bit          f_end = 0, d_end = 0;
    bit          running = 0, quiesce = 0, did_rst = 0;
    bit          mreq_prev = 0;

    task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_mem_req"}, mem_req, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_be"}, mem_be, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_if_ready"}, if_ready, 0);
        chk({tag, "_d_ready"}, d_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_if_rdata"}, if_rdata, 0);
        chk({tag, "_d_rdata"}, d_rdata, 0);
    endtask

    task automatic model_step();
        bit   ifr, dr, de, fe, gf, gd;
        mtx_t t;
        ifr = 0;
        dr = 0;
        f_end = m_ifr || if_abort;
        d_end = m_dr;
        if (m_owner == 0) begin
            de = d_req && !m_dr;
            fe = if_req && !if_abort && !m_ifr;
            gf = fe && (!de || m_cnt == MAXS);
            gd = de && !gf;
            if (!if_req || gf) m_cnt = 0;
            else if (gd && !if_abort && m_cnt < MAXS) m_cnt++;
            if (gf) begin
                t = '{fetch: 1'b1, we: 1'b0, be: 4'hf,
                      addr: if_addr, wdata: 32'h0};
                mq.push_back(t);
                m_owner = 1;
                m_disc = 0;
                wait_cnt = $urandom_range(1, 3);
            end else if (gd) begin
                t = '{fetch: 1'b0, we: d_we, be: d_be,
                      addr: d_addr, wdata: d_wdata};
                mq.push_back(t);
                m_dwe = d_we;
                m_owner = 2;
                wait_cnt = $urandom_range(1, 3);
            end
        end else begin
            if (!if_req) m_cnt = 0;
            if (m_owner == 1) begin
                if (if_abort) m_disc = 1;
                if (mem_ack) begin
                    if (!m_disc) begin
                        ifr = 1;
                        m_ifrd = mem_rdata;
                        ifq.push_back(mem_rdata);
                    end
                    m_disc = 0;
                    m_owner = 0;
                end
            end else if (mem_ack) begin
                if (!m_dwe) m_drd = mem_rdata;
                dq.push_back(m_drd);
                dr = 1;
                m_owner = 0;
            end
        end
        m_ifr = ifr;
        m_dr = dr;
    endtask

    task automatic drive();
        mem_rdata = $urandom;
        if (m_owner != 0) begin
            if (wait_cnt == 0) mem_ack = 1'b1;
            else begin
                mem_ack = 1'b0;
                wait_cnt--;
            end
        end else begin
            mem_ack = ($urandom_range(0, 7) == 0);
        end
        if (if_req && f_end) if_req = 1'b0;
        if (!if_req && !quiesce && $urandom_range(0, 2) == 0) begin
            if_req = 1'b1;
            if_addr = $urandom & 32'hffff_fffc;
        end
        if_abort = ($urandom_range(0, 15) == 0);
        if (d_req && d_end) d_req = 1'b0;
        if (!d_req && !quiesce && $urandom_range(0, 2) == 0) begin
            d_req = 1'b1;
            d_we = $urandom_range(0, 1);
            d_be = $urandom_range(1, 15);
            d_addr = $urandom & 32'hffff_fffc;
            d_wdata = $urandom;
        end
    endtask

    task automatic mid_reset();
        #1 reset_n = 1'b0;
        #1 chk_zero("midrst");
        m_owner = 0; m_cnt = 0; m_disc = 0;
        m_ifr = 0; m_dr = 0; m_ifrd = '0; m_drd = '0;
        f_end = 0; d_end = 0;
        mq.delete(); ifq.delete(); dq.delete();
        if_req = 1'b0; d_req = 1'b0; if_abort = 1'b0; mem_ack = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        did_rst = 1;
    endtask

    always @(negedge clk) begin
        if (!reset_n || !running) begin
            mreq_prev = 0;
        end else begin
            chk("busy", busy, m_owner != 0);
            chk("mem_req", mem_req, m_owner != 0);
            chk("if_ready", if_ready, m_ifr);
            chk("d_ready", d_ready, m_dr);
            chk("stall_if", stall_if, if_req & ~m_ifr & ~if_abort);
            chk("stall_mem", stall_mem, d_req & ~m_dr);
            chk("if_rdata_hold", if_rdata, m_ifrd);
            chk("d_rdata_hold", d_rdata, m_drd);
            if (mem_req && !mreq_prev) begin
                checks++;
                if (mq.size() == 0) begin
                    errs++;
                    $display("FAIL mem_issue: got request at %0h, none expected",
                             mem_addr);
                end else begin
                    cur = mq.pop_front();
                    chk("mem_addr", mem_addr, cur.addr);
                    chk("mem_we", mem_we, cur.we);
                    chk("mem_be", mem_be, cur.be);
                    if (!cur.fetch) chk("mem_wdata", mem_wdata, cur.wdata);
                end
            end
            if (mem_req) chk("mem_addr_stable", mem_addr, cur.addr);
            mreq_prev = mem_req;
            if (if_ready) begin
                checks++;
                if (ifq.size() == 0) begin
                    errs++;
                    $display("FAIL if_resp: got %0h, none expected", if_rdata);
                end else begin
                    chk("if_resp", if_rdata, ifq.pop_front());
                end
            end
            if (d_ready) begin
                checks++;
                if (dq.size() == 0) begin
                    errs++;
                    $display("FAIL d_resp: got %0h, none expected", d_rdata);
                end else begin
                    chk("d_resp", d_rdata, dq.pop_front());
                end
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        chk_zero("reset");
        chk("reset_stall_if", stall_if, 0);
        chk("reset_stall_mem", stall_mem, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        running = 1;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            model_step();
            #1 drive();
            if (c > 1500 && !did_rst && m_owner == 2) mid_reset();
            if (c == 3950) quiesce = 1;
        end
        chk("reset_hit", did_rst, 1);
        chk("left_mem_txn", mq.size(), 0);
        chk("left_if_resp", ifq.size(), 0);
        chk("left_d_resp", dq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
